// File: rtl/imgproc_cfg_sequencer.sv
// Frame-synchronous configuration sequencer: the CPU edits a shadow register bank, and only
// the changed registers are copied to the image processor while no frame is in flight.
module imgproc_cfg_sequencer #(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 32,
  parameter int READ_LAT    = 1,
  parameter int STATUS_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_chipselect,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [3:0]        c_address,
  input  logic [DATA_W-1:0] c_writedata,
  output logic [DATA_W-1:0] c_readdata,
  input  logic              mon_valid,
  input  logic              mon_ready,
  input  logic              mon_sop,
  input  logic              mon_eop,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_write,
  output logic [2:0]        m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              irq
);

  localparam int IDX_W = 3;
  localparam int CNT_W = $clog2(READ_LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_GAP  = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_REQ  = 3'd3,
    S_READ_WAIT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic                rb_en_q, rb_en_d, irq_en_q, irq_en_d;
  logic                pending_q, pending_d, torn_q, torn_d;
  logic                commit_done_q, commit_done_d, rb_done_q, rb_done_d;
  logic [DATA_W-1:0]   readback_q, readback_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                in_frame_q, in_frame_d, eop_seen_q, eop_seen_d;
  logic                busy_q, busy_d, irq_q, irq_d;
  logic                m_cs_q, m_cs_d, m_read_q, m_read_d, m_write_q, m_write_d;
  logic [IDX_W-1:0]    m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
  logic [DATA_W-1:0]   c_readdata_q, c_readdata_d, rdata_s;
  logic                cpu_wr_s, cpu_rd_s, sop_acc_s, eop_acc_s, any_dirty_s;
  logic [IDX_W-1:0]    wr_idx_s;

  assign cpu_wr_s  = c_chipselect & c_write;
  assign cpu_rd_s  = c_chipselect & c_read;
  assign sop_acc_s = mon_valid & mon_ready & mon_sop;
  assign eop_acc_s = mon_valid & mon_ready & mon_eop;

  // Lowest-index dirty register wins; scanning downward leaves the smallest index last.
  always_comb begin
    any_dirty_s = 1'b0;
    wr_idx_s    = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      any_dirty_s = any_dirty_s | dirty_q[i];
      wr_idx_s    = dirty_q[i] ? IDX_W'(i) : wr_idx_s;
    end
  end

  // Frame tracking; an SOP+EOP single-beat frame leaves in_frame clear.
  always_comb begin
    if (eop_acc_s) begin
      in_frame_d = 1'b0;
    end else if (sop_acc_s) begin
      in_frame_d = 1'b1;
    end else begin
      in_frame_d = in_frame_q;
    end
    frame_count_d = eop_acc_s ? frame_count_q + 16'd1 : frame_count_q;
    eop_seen_d    = eop_acc_s;
  end

  // CPU read mux.
  always_comb begin
    case (c_address)
      4'd8:    rdata_s = {{(DATA_W-3){1'b0}}, irq_en_q, rb_en_q, 1'b0};
      4'd9:    rdata_s = {{(DATA_W-5){1'b0}}, rb_done_q, commit_done_q, torn_q, pending_q, busy_q};
      4'd10:   rdata_s = readback_q;
      4'd11:   rdata_s = {{(DATA_W-16){1'b0}}, frame_count_q};
      default: rdata_s = (c_address < 4'(NUM_REGS)) ? shadow_q[c_address[IDX_W-1:0]] : '0;
    endcase
    c_readdata_d = cpu_rd_s ? rdata_s : c_readdata_q;
  end

  // Sequencer FSM plus CPU register updates; ordering encodes set/clear priorities.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    dirty_d       = dirty_q;
    rb_en_d       = rb_en_q;
    irq_en_d      = irq_en_q;
    pending_d     = pending_q;
    torn_d        = torn_q;
    commit_done_d = commit_done_q;
    rb_done_d     = rb_done_q;
    readback_d    = readback_q;
    rd_cnt_d      = rd_cnt_q;
    m_cs_d        = 1'b0;
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    m_address_d   = '0;
    m_writedata_d = '0;

    // Write-1-to-clear first so a same-cycle hardware set survives.
    if (cpu_wr_s && (c_address == 4'd9)) begin
      torn_d        = torn_q & ~c_writedata[2];
      commit_done_d = commit_done_q & ~c_writedata[3];
      rb_done_d     = rb_done_q & ~c_writedata[4];
    end else begin
      torn_d = torn_q;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d = S_WAIT_GAP;
        end else if (eop_seen_q && rb_en_q) begin
          state_d = S_READ_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_GAP: begin
        if (!in_frame_d && !sop_acc_s) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT_GAP;
        end
      end
      S_WRITE: begin
        if (sop_acc_s) begin
          torn_d  = 1'b1;
          state_d = S_WAIT_GAP;
        end else if (any_dirty_s) begin
          m_cs_d             = 1'b1;
          m_write_d          = 1'b1;
          m_address_d        = wr_idx_s;
          m_writedata_d      = shadow_q[wr_idx_s];
          dirty_d[wr_idx_s]  = 1'b0;
        end else begin
          pending_d     = 1'b0;
          commit_done_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_READ_REQ: begin
        m_cs_d      = 1'b1;
        m_read_d    = 1'b1;
        m_address_d = IDX_W'(STATUS_ADDR);
        rd_cnt_d    = '0;
        state_d     = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (rd_cnt_q == CNT_W'(READ_LAT)) begin
          readback_d = m_readdata;
          rb_done_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // CPU writes last: a shadow write re-dirties a register issued this same cycle.
    if (cpu_wr_s) begin
      if (c_address < 4'(NUM_REGS)) begin
        shadow_d[c_address[IDX_W-1:0]] = c_writedata;
        dirty_d[c_address[IDX_W-1:0]]  = 1'b1;
      end else if (c_address == 4'd8) begin
        rb_en_d   = c_writedata[1];
        irq_en_d  = c_writedata[2];
        pending_d = pending_d | c_writedata[0];
      end else begin
        pending_d = pending_d;
      end
    end else begin
      pending_d = pending_d;
    end

    busy_d = (state_d != S_IDLE);
    irq_d  = irq_en_q & (commit_done_q | rb_done_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      dirty_q       <= '0;
      rb_en_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      pending_q     <= 1'b0;
      torn_q        <= 1'b0;
      commit_done_q <= 1'b0;
      rb_done_q     <= 1'b0;
      readback_q    <= '0;
      rd_cnt_q      <= '0;
      frame_count_q <= 16'd0;
      in_frame_q    <= 1'b0;
      eop_seen_q    <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      m_cs_q        <= 1'b0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      c_readdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dirty_q       <= dirty_d;
      rb_en_q       <= rb_en_d;
      irq_en_q      <= irq_en_d;
      pending_q     <= pending_d;
      torn_q        <= torn_d;
      commit_done_q <= commit_done_d;
      rb_done_q     <= rb_done_d;
      readback_q    <= readback_d;
      rd_cnt_q      <= rd_cnt_d;
      frame_count_q <= frame_count_d;
      in_frame_q    <= in_frame_d;
      eop_seen_q    <= eop_seen_d;
      busy_q        <= busy_d;
      irq_q         <= irq_d;
      m_cs_q        <= m_cs_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      c_readdata_q  <= c_readdata_d;
    end
  end

  assign c_readdata   = c_readdata_q;
  assign m_chipselect = m_cs_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_address    = m_address_q;
  assign m_writedata  = m_writedata_q;
  assign frame_count  = frame_count_q;
  assign busy         = busy_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_imgproc_cfg_sequencer.sv
// Directed bench for imgproc_cfg_sequencer: expected master writes are queued when the
// shadow registers are written and checked as they appear on the master bus.
module tb_imgproc_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        c_chipselect = 1'b0, c_read = 1'b0, c_write = 1'b0;
  logic [3:0]  c_address = 4'd0;
  logic [31:0] c_writedata = 32'd0;
  logic [31:0] c_readdata;
  logic        mon_valid = 1'b0, mon_ready = 1'b0, mon_sop = 1'b0, mon_eop = 1'b0;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'hCAFE0001;
  logic [15:0] frame_count;
  logic        busy, irq;

  imgproc_cfg_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .c_chipselect(c_chipselect), .c_read(c_read), .c_write(c_write),
    .c_address(c_address), .c_writedata(c_writedata), .c_readdata(c_readdata),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_sop(mon_sop), .mon_eop(mon_eop),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .frame_count(frame_count), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int n_reads  = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample_bus();
    logic [34:0] e;
    if (reset_n && m_chipselect && m_write) begin
      n_writes++;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0d data %h expected no write", m_address, m_writedata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", {29'd0, m_address}, {29'd0, e[34:32]});
        check("wr_data", m_writedata, e[31:0]);
      end
    end
    if (reset_n && m_chipselect && m_read) begin
      n_reads++;
      check("rd_addr", {29'd0, m_address}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_bus();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    c_chipselect = 1'b1; c_write = 1'b1; c_address = a; c_writedata = d;
    tick();
    c_chipselect = 1'b0; c_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    c_chipselect = 1'b1; c_read = 1'b1; c_address = a;
    tick();
    d = c_readdata;
    c_chipselect = 1'b0; c_read = 1'b0;
  endtask

  task automatic beat(input logic sop, input logic eop);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_sop = sop; mon_eop = eop;
    tick();
    mon_valid = 1'b0; mon_ready = 1'b0; mon_sop = 1'b0; mon_eop = 1'b0;
  endtask

  task automatic wait_wr_addr(input logic [2:0] a, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (m_write && m_address == a) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_done(input int budget, output logic [31:0] st);
    st = 32'd0;
    for (int i = 0; i < budget && !st[3]; i++) cpu_read(4'd9, st);
  endtask

  function automatic logic [34:0] wr(input logic [2:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  logic [31:0] rd;
  logic        ok;
  int          base, seen, rbase;

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_strobes", {26'd0, m_chipselect, m_read, m_write, busy, irq, 1'b0}, 32'd0);
    check("rst_maddr", {29'd0, m_address}, 32'd0);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_fcount", {16'd0, frame_count}, 32'd0);
    cpu_read(4'd9, rd);
    check("rst_status", rd, 32'd0);

    // Commit outside a frame: addr1 then addr3 back to back.
    cpu_write(4'd1, 32'h11); exp_q.push_back(wr(3'd1, 32'h11));
    cpu_write(4'd3, 32'h33); exp_q.push_back(wr(3'd3, 32'h33));
    cpu_write(4'd8, 32'h1);
    wait_wr_addr(3'd1, 10, ok);
    check("t1_first_write", {31'd0, ok}, 32'd1);
    tick();
    check("t1_consecutive", {28'd0, m_write, m_address}, {28'd0, 1'b1, 3'd3});
    repeat (3) tick();
    cpu_read(4'd9, rd);
    check("t1_status", rd, 32'h8);
    cpu_write(4'd9, 32'h1C);

    // Commit inside a frame: held until the EOP.
    beat(1'b1, 1'b0);
    cpu_write(4'd5, 32'h55); exp_q.push_back(wr(3'd5, 32'h55));
    base = n_writes;
    cpu_write(4'd8, 32'h1);
    repeat (10) tick();
    check("t2_no_write_in_frame", n_writes, base);
    cpu_read(4'd9, rd);
    check("t2_status_waiting", rd, 32'h3);
    beat(1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      tick();
      if (m_write) ok = 1'b1;
    end
    check("t2_write_after_eop", {31'd0, ok}, 32'd1);
    repeat (3) tick();
    check("t2_count", n_writes - base, 1);
    cpu_write(4'd9, 32'h1C);

    // Torn commit: SOP during the third write, remainder after the next EOP.
    for (int i = 0; i < 6; i++) cpu_write(4'(i), 32'hA0 + i);
    for (int i = 0; i < 3; i++) exp_q.push_back(wr(3'(i), 32'hA0 + i));
    base = n_writes;
    cpu_write(4'd8, 32'h1);
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      tick();
      if (m_write) seen++;
    end
    check("t3_reached_third", seen, 3);
    beat(1'b1, 1'b0);
    repeat (5) tick();
    check("t3_torn_count", n_writes - base, 3);
    cpu_read(4'd9, rd);
    check("t3_status_torn", rd, 32'h7);
    for (int i = 3; i < 6; i++) exp_q.push_back(wr(3'(i), 32'hA0 + i));
    beat(1'b0, 1'b1);
    wait_done(20, rd);
    check("t3_status_done", rd, 32'hC);
    check("t3_total_count", n_writes - base, 6);
    cpu_write(4'd9, 32'h1C);

    // Auto-readback with irq.
    cpu_write(4'd8, 32'h6);
    rbase = n_reads;
    beat(1'b0, 1'b1);
    repeat (8) tick();
    check("t4_one_read", n_reads - rbase, 1);
    cpu_read(4'd10, rd);
    check("t4_readback", rd, 32'hCAFE0001);
    check("t4_irq_set", {31'd0, irq}, 32'd1);
    cpu_read(4'd9, rd);
    check("t4_status", rd, 32'h10);
    cpu_read(4'd8, rd);
    check("t4_ctrl_read", rd, 32'h6);
    cpu_write(4'd9, 32'h10);
    repeat (2) tick();
    check("t4_irq_cleared", {31'd0, irq}, 32'd0);
    cpu_write(4'd8, 32'h0);

    // CPU rewrites reg2 in the cycle the sequencer issues it.
    cpu_write(4'd0, 32'hB0); exp_q.push_back(wr(3'd0, 32'hB0));
    cpu_write(4'd1, 32'hB1); exp_q.push_back(wr(3'd1, 32'hB1));
    cpu_write(4'd2, 32'hB2); exp_q.push_back(wr(3'd2, 32'hB2));
    exp_q.push_back(wr(3'd2, 32'hBEEF));
    base = n_writes;
    cpu_write(4'd8, 32'h1);
    wait_wr_addr(3'd1, 20, ok);
    check("t5_saw_reg1", {31'd0, ok}, 32'd1);
    cpu_write(4'd2, 32'hBEEF);
    wait_done(20, rd);
    check("t5_done", rd & 32'h8, 32'h8);
    check("t5_count", n_writes - base, 4);
    check("t5_queue_empty", exp_q.size(), 0);
    cpu_read(4'd13, rd);
    check("unmapped_read", rd, 32'd0);
    cpu_write(4'd9, 32'h1C);

    // Asynchronous reset in the middle of a write.
    cpu_write(4'd7, 32'h77); exp_q.push_back(wr(3'd7, 32'h77));
    cpu_write(4'd8, 32'h1);
    wait_wr_addr(3'd7, 20, ok);
    check("t6_in_write", {31'd0, ok}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_strobes", {27'd0, m_chipselect, m_read, m_write, busy, irq}, 32'd0);
    check("t6_maddr_wdata", {m_writedata[28:0], m_address}, 32'd0);
    check("t6_fcount", {16'd0, frame_count}, 32'd0);
    check("t6_creaddata", c_readdata, 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    cpu_read(4'd7, rd);
    check("t6_shadow_cleared", rd, 32'd0);
    cpu_read(4'd9, rd);
    check("t6_status_cleared", rd, 32'd0);

    // Frame counter wrap.
    mon_valid = 1'b1; mon_ready = 1'b1; mon_eop = 1'b1;
    repeat (65535) tick();
    check("t7_fcount_max", {16'd0, frame_count}, 32'h0000FFFF);
    tick();
    check("t7_fcount_wrap", {16'd0, frame_count}, 32'd0);
    mon_valid = 1'b0; mon_ready = 1'b0; mon_eop = 1'b0;

    // Single-beat frame (SOP and EOP together) leaves the gap open.
    cpu_write(4'd4, 32'h44); exp_q.push_back(wr(3'd4, 32'h44));
    beat(1'b1, 1'b1);
    cpu_write(4'd8, 32'h1);
    wait_wr_addr(3'd4, 6, ok);
    check("t8_sop_eop_gap", {31'd0, ok}, 32'd1);
    repeat (3) tick();
    check("t8_fcount", {16'd0, frame_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imgproc_cfg_sequencer.md
Name: imgproc_cfg_sequencer

Overview:
Frame-synchronous configuration controller for the image-processing block's Avalon-MM register slave. The CPU writes a shadow register bank at any time and requests a commit. The sequencer then replays only the changed registers to the processor, and only in the inter-frame gap (after EOP, before the next SOP), so thresholds and modes never change mid-frame. It can also read back a processor status register once per frame, count frames, and raise an interrupt.

Parameters:
NUM_REGS, 8, shadow registers mirrored to processor addresses 0..NUM_REGS-1
DATA_W, 32, register data width
READ_LAT, 1, cycles from m_read to valid m_readdata
STATUS_ADDR, 0, processor address read on auto-readback

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
c_chipselect  in  1  CPU slave select
c_read  in  1  CPU read strobe
c_write  in  1  CPU write strobe
c_address  in  4  CPU register address
c_writedata  in  32  CPU write data
c_readdata  out  32  CPU read data, registered, valid the cycle after c_read
mon_valid  in  1  tap of processor sink valid
mon_ready  in  1  tap of processor sink ready
mon_sop  in  1  tap of processor sink start-of-packet
mon_eop  in  1  tap of processor sink end-of-packet
m_chipselect  out  1  master select to processor slave
m_read  out  1  master read strobe
m_write  out  1  master write strobe
m_address  out  3  master address
m_writedata  out  32  master write data
m_readdata  in  32  processor read data
frame_count  out  16  accepted-EOP counter
busy  out  1  FSM not in IDLE
irq  out  1  OR of enabled sticky flags

Behaviour:
- Reset clears all outputs, shadow registers, dirty bits, flags, frame_count and in_frame. The FSM returns to IDLE from any state, and an in-progress master access is dropped.
- CPU address map:
  - 0..7: shadow registers. A write sets the corresponding dirty bit.
  - 8: control. Bit0 is commit request (write-only, sets pending). Bit1 is auto-readback enable. Bit2 is irq enable.
  - 9: status. Bit0 busy, bit1 pending, bit2 torn, bit3 commit_done, bit4 readback_done. Bits 2-4 are write-1-to-clear.
  - 10: last readback value.
  - 11: frame_count.
  - Reads of unmapped addresses return 0.
- A beat is accepted when mon_valid & mon_ready.
- in_frame is set on an accepted SOP and cleared on an accepted EOP. If SOP and EOP occur in the same beat, in_frame ends at 0.
- frame_count increments on each accepted EOP and wraps 0xFFFF -> 0.
- FSM states:
  - IDLE -> WAIT_GAP when pending.
  - WAIT_GAP -> WRITE when in_frame=0 and no SOP is accepted in the same cycle.
  - WRITE issues one single-cycle write per cycle. It selects the lowest-index dirty register: m_chipselect=m_write=1, m_address=index, m_writedata=shadow value.
  - In WRITE, the dirty bit is cleared in the issue cycle. If the CPU writes the same register in that cycle, the CPU write wins and the dirty bit stays set.
  - When no dirty bit remains in WRITE: clear pending, set commit_done, go to IDLE.
  - Accepted SOP during WRITE: the write already driven that cycle completes. Set torn, go to WAIT_GAP, and resume with the remaining dirty bits at the next gap.
  - Commit with no dirty bits: pending clears and commit_done is set with zero master writes.
  - READ_REQ is entered from IDLE on the cycle after an accepted EOP, when auto-readback is enabled and pending=0. It drives m_chipselect=m_read=1 with m_address=STATUS_ADDR for one cycle.
  - READ_WAIT: capture m_readdata READ_LAT cycles after the m_read cycle, set readback_done, go to IDLE.
  - If commit and readback trigger in the same cycle, commit has priority and that frame's readback is skipped.
- Master strobes are single-cycle and registered; no two master accesses overlap.
- irq = ctrl[2] & (commit_done | readback_done), registered.
- A commit request while busy only re-asserts pending; new dirty bits are picked up by the in-progress WRITE.

Test Plan:
- Reset: write regs 1 and 3 (0x11, 0x33), commit with in_frame=0. Required: writes at addr1 then addr3 on consecutive cycles, then commit_done=1 and pending=0.
- Accepted SOP, then commit. Required: no master write until the accepted EOP; then the writes occur within 2 cycles.
- Dirty regs 0..5, SOP accepted during the 3rd write. Required: exactly 3 writes and torn=1; after the next EOP, regs 3..5 are written.
- Auto-readback and irq enabled, m_readdata=0xCAFE0001 on an EOP. Required: one m_read to addr 0, readback reg = 0xCAFE0001, irq=1. Writing 0x10 to addr 9 clears irq.
- CPU writes reg 2 in the same cycle the sequencer issues reg 2. Required: dirty[2] remains set and a second write carries the new value.
- Drive 65536 EOPs. Required: frame_count returns to 0. Assert reset_n low mid-WRITE: all outputs are 0 immediately.
